simple_bus_arbiter: RTL and testbench



---
 rtl/simple_bus_pkg.sv | 18 +
 rtl/simple_bus_arbiter_rr_pick.sv | 32 +++
 rtl/simple_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_simple_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_bus_pkg.sv
// Shared types and default sizes for the simple bus arbiter.
// Imported by the arbiter top and its round-robin picker.
package simple_bus_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_MODE_W  = 2;
  localparam int DEF_TIMEOUT = 15;
  localparam int XFER_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BUSY
  } state_t;

endpackage

// File: rtl/simple_bus_arbiter_rr_pick.sv
// Round-robin winner search starting just above last_owner.
// Purely combinational; wraps modulo NUM_REQ.
module rr_pick
  import simple_bus_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_owner,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int OW = $clog2(NUM_REQ);

  int j;

  // Walk from the farthest slot down so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = (int'(last_owner) + i) % NUM_REQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = OW'(j);
      end
    end
  end

endmodule

// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter that hands one shared resource to one
// requester at a time, with a timeout on the resource reply.
module simple_bus_arbiter
  import simple_bus_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MODE_W  = DEF_MODE_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic [NUM_REQ-1:0]        m_start,
  input  logic [NUM_REQ*ADDR_W-1:0] m_addr,
  input  logic [NUM_REQ*DATA_W-1:0] m_data,
  input  logic [NUM_REQ*MODE_W-1:0] m_mode,
  output logic [NUM_REQ-1:0]        m_ready,
  output logic                      s_start,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_data,
  output logic [MODE_W-1:0]         s_mode,
  input  logic                      s_ready,
  output logic                      err,
  output logic [XFER_W-1:0]         xfer_cnt
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t              state;
  state_t              state_d;
  logic [OW-1:0]       owner;
  logic [OW-1:0]       owner_d;
  logic [OW-1:0]       last_owner;
  logic [OW-1:0]       last_d;
  logic [TW-1:0]       tcnt;
  logic [TW-1:0]       tcnt_d;
  logic [NUM_REQ-1:0]  gnt_d;
  logic [NUM_REQ-1:0]  m_ready_d;
  logic                s_start_d;
  logic                err_d;
  logic [ADDR_W-1:0]   s_addr_d;
  logic [DATA_W-1:0]   s_data_d;
  logic [MODE_W-1:0]   s_mode_d;
  logic [XFER_W-1:0]   xfer_cnt_d;

  logic                pick_valid;
  logic [OW-1:0]       pick_idx;
  logic [NUM_REQ-1:0]  own_oh;
  logic                timed_out;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  assign own_oh    = NUM_REQ'(1) << owner;
  assign timed_out = (tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state;
    owner_d    = owner;
    last_d     = last_owner;
    tcnt_d     = tcnt;
    gnt_d      = gnt;
    m_ready_d  = '0;
    s_start_d  = 1'b0;
    err_d      = 1'b0;
    s_addr_d   = s_addr;
    s_data_d   = s_data;
    s_mode_d   = s_mode;
    xfer_cnt_d = xfer_cnt;
    unique case (state)
      IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          owner_d = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (m_start[owner]) begin
          s_addr_d  = m_addr[int'(owner)*ADDR_W +: ADDR_W];
          s_data_d  = m_data[int'(owner)*DATA_W +: DATA_W];
          s_mode_d  = m_mode[int'(owner)*MODE_W +: MODE_W];
          s_start_d = 1'b1;
          tcnt_d    = '0;
          state_d   = BUSY;
        end else if (!req[owner]) begin
          gnt_d   = '0;
          last_d  = owner;
          state_d = IDLE;
        end
      end
      BUSY: begin
        // A reply in the final timeout cycle still counts as success.
        if (s_ready) begin
          m_ready_d  = own_oh;
          xfer_cnt_d = xfer_cnt + XFER_W'(1);
          gnt_d      = '0;
          last_d     = owner;
          state_d    = IDLE;
        end else if (timed_out) begin
          err_d   = 1'b1;
          gnt_d   = '0;
          last_d  = owner;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt + TW'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(NUM_REQ - 1);
      tcnt       <= '0;
      gnt        <= '0;
      m_ready    <= '0;
      s_start    <= 1'b0;
      err        <= 1'b0;
      s_addr     <= '0;
      s_data     <= '0;
      s_mode     <= '0;
      xfer_cnt   <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_owner <= last_d;
      tcnt       <= tcnt_d;
      gnt        <= gnt_d;
      m_ready    <= m_ready_d;
      s_start    <= s_start_d;
      err        <= err_d;
      s_addr     <= s_addr_d;
      s_data     <= s_data_d;
      s_mode     <= s_mode_d;
      xfer_cnt   <= xfer_cnt_d;
    end
  end

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Randomized transaction-level bench for simple_bus_arbiter.
// Expected grants, fields, pulses and counts come from a small model.
module tb_simple_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] m_start;
  logic [N*8-1:0] m_addr;
  logic [N*8-1:0] m_data;
  logic [N*2-1:0] m_mode;
  logic [N-1:0] m_ready;
  logic         s_start;
  logic [7:0]   s_addr;
  logic [7:0]   s_data;
  logic [1:0]   s_mode;
  logic         s_ready;
  logic         err;
  logic [15:0]  xfer_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int last;
  logic [15:0] cnt;

  simple_bus_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (8),
    .DATA_W  (8),
    .MODE_W  (2),
    .TIMEOUT (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .m_start  (m_start),
    .m_addr   (m_addr),
    .m_data   (m_data),
    .m_mode   (m_mode),
    .m_ready  (m_ready),
    .s_start  (s_start),
    .s_addr   (s_addr),
    .s_data   (s_data),
    .s_mode   (s_mode),
    .s_ready  (s_ready),
    .err      (err),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int lo);
    for (int i = 1; i <= N; i++)
      if (r[(lo + i) % N]) return (lo + i) % N;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    m_start = '0;
    s_ready = 1'b0;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_mready", 32'(m_ready), 0);
    chk("rst_sstart", 32'(s_start), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_saddr", 32'(s_addr), 0);
    chk("rst_sdata", 32'(s_data), 0);
    chk("rst_smode", 32'(s_mode), 0);
    chk("rst_cnt", 32'(xfer_cnt), 0);
    rst = 1'b0;
    last = N - 1;
    cnt = '0;
  endtask

  task automatic idle_chk(input int n);
    req = '0;
    for (int k = 0; k < n; k++) begin
      m_start = 4'($urandom);
      s_ready = 1'($urandom);
      @(negedge clk);
      chk("idle_gnt", 32'(gnt), 0);
      chk("idle_sstart", 32'(s_start), 0);
      chk("idle_mready", 32'(m_ready), 0);
    end
    m_start = '0;
  endtask

  task automatic run_xfer(input logic [N-1:0] reqs, input int sdly,
                          input int rdly, input bit drop,
                          input int rst_at);
    int w;
    logic [N-1:0] own;
    logic [7:0] ea;
    logic [7:0] ed;
    logic [1:0] em;
    w = pick(reqs, last);
    own = 4'b0001 << w;
    req = reqs;
    m_start = '0;
    s_ready = 1'($urandom);
    @(negedge clk);
    chk("grant", 32'(gnt), 32'(own));
    chk("gnt_sstart", 32'(s_start), 0);
    chk("gnt_mready", 32'(m_ready), 0);
    chk("gnt_err", 32'(err), 0);
    chk("gnt_cnt", 32'(xfer_cnt), 32'(cnt));
    if (drop) begin
      req = 4'($urandom) & ~own;
      m_start = 4'($urandom) & ~own;
      @(negedge clk);
      chk("drop_gnt", 32'(gnt), 0);
      chk("drop_sstart", 32'(s_start), 0);
      last = w;
      req = '0;
      m_start = '0;
      return;
    end
    for (int k = 0; k < sdly; k++) begin
      req = 4'($urandom) | own;
      m_start = 4'($urandom) & ~own;
      s_ready = 1'($urandom);
      @(negedge clk);
      chk("wait_gnt", 32'(gnt), 32'(own));
      chk("wait_sstart", 32'(s_start), 0);
      chk("wait_mready", 32'(m_ready), 0);
    end
    m_addr = $urandom;
    m_data = $urandom;
    m_mode = 8'($urandom);
    m_start = own | 4'($urandom);
    s_ready = 1'($urandom);
    req = 4'($urandom) | own;
    ea = m_addr[w*8 +: 8];
    ed = m_data[w*8 +: 8];
    em = m_mode[w*2 +: 2];
    @(negedge clk);
    m_start = '0;
    chk("sstart", 32'(s_start), 1);
    chk("saddr", 32'(s_addr), 32'(ea));
    chk("sdata", 32'(s_data), 32'(ed));
    chk("smode", 32'(s_mode), 32'(em));
    chk("busy_gnt", 32'(gnt), 32'(own));
    for (int j = 0; j <= TO; j++) begin
      if (j == rst_at) begin
        do_reset();
        return;
      end
      if (j == TO) begin
        chk("to_err", 32'(err), 1);
        chk("to_mready", 32'(m_ready), 0);
        chk("to_gnt", 32'(gnt), 0);
        chk("to_cnt", 32'(xfer_cnt), 32'(cnt));
        last = w;
        req = '0;
        s_ready = 1'b0;
        return;
      end
      req = 4'($urandom);
      m_addr = $urandom;
      m_data = $urandom;
      m_mode = 8'($urandom);
      m_start = 4'($urandom) & ~own;
      s_ready = (j == rdly);
      @(negedge clk);
      if (j == rdly) begin
        s_ready = 1'b0;
        m_start = '0;
        cnt = cnt + 16'd1;
        chk("done_mready", 32'(m_ready), 32'(own));
        chk("done_err", 32'(err), 0);
        chk("done_gnt", 32'(gnt), 0);
        chk("done_cnt", 32'(xfer_cnt), 32'(cnt));
        last = w;
        req = '0;
        return;
      end
      if (j < TO - 1) begin
        chk("hold_gnt", 32'(gnt), 32'(own));
        chk("hold_mready", 32'(m_ready), 0);
        chk("hold_err", 32'(err), 0);
        chk("hold_sstart", 32'(s_start), 0);
        chk("hold_saddr", 32'(s_addr), 32'(ea));
        chk("hold_sdata", 32'(s_data), 32'(ed));
        chk("hold_smode", 32'(s_mode), 32'(em));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [N-1:0] r;
    int sd;
    int rd;
    bit dr;
    int ra;
    rst = 1'b1;
    req = '0;
    m_start = '0;
    m_addr = '0;
    m_data = '0;
    m_mode = '0;
    s_ready = 1'b0;
    last = N - 1;
    cnt = '0;
    do_reset();
    idle_chk(3);
    repeat (5) run_xfer(4'hF, 0, 0, 1'b0, -1);
    run_xfer(4'b0100, 1, 2, 1'b0, -1);
    run_xfer(4'hF, 0, 20, 1'b0, -1);
    run_xfer(4'hF, 0, 14, 1'b0, -1);
    run_xfer(4'hF, 1, 0, 1'b1, -1);
    run_xfer(4'hF, 2, 1, 1'b0, -1);
    run_xfer(4'h8, 3, 3, 1'b0, 2);
    run_xfer(4'h9, 0, 0, 1'b0, -1);
    for (int t = 0; t < 80; t++) begin
      r  = 4'($urandom_range(1, 15));
      sd = $urandom_range(0, 3);
      rd = ($urandom_range(0, 4) == 0) ? $urandom_range(13, 17)
                                       : $urandom_range(0, 5);
      dr = ($urandom_range(0, 7) == 0);
      ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1;
      if ($urandom_range(0, 9) == 0) idle_chk(2);
      run_xfer(r, sd, rd, dr, ra);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
